// File: rtl/md_issue_ctrl_pkg.sv
// Shared decode constants, field helpers and FSM state encoding for the
// multiply/divide issue controller.
package md_issue_ctrl_pkg;

    // Primary opcode shared by every HI/LO-class instruction
    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    // Function codes of the multiply/divide family
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Latency tracker state: which kind of operation is outstanding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    // Primary opcode field
    function automatic logic [5:0] op_field(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    // Function code field
    function automatic logic [5:0] func_field(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/md_decode.sv
// Combinational classifier for multiply/divide-family instructions.
// Only the opcode and function fields take part in the decision.
module md_decode
    import md_issue_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_start,
    output logic        is_mul,
    output logic        is_div,
    output logic        is_mfhi,
    output logic        is_mflo,
    output logic        is_mdclass
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       special;
    logic       is_mthi;
    logic       is_mtlo;
    logic       unused_bits;

    assign op      = op_field(instr);
    assign fn      = func_field(instr);
    assign special = (op == OP_SPECIAL);

    // Register-specifier bits play no part in classification
    assign unused_bits = ^instr[25:6];

    // Classify by function code once the opcode is SPECIAL
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mfhi = 1'b0;
        is_mflo = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        if (special) begin
            is_mul  = (fn == FN_MULT) || (fn == FN_MULTU);
            is_div  = (fn == FN_DIV)  || (fn == FN_DIVU);
            is_mfhi = (fn == FN_MFHI);
            is_mflo = (fn == FN_MFLO);
            is_mthi = (fn == FN_MTHI);
            is_mtlo = (fn == FN_MTLO);
        end
    end

    assign is_start   = is_mul | is_div;
    assign is_mdclass = is_start | is_mfhi | is_mflo | is_mthi | is_mtlo;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue and hazard controller for the multiply/divide unit.
// Issues start pulses, mirrors the unit's latency in a private FSM, stalls
// HI/LO-class instructions in D while an operation is outstanding, muxes the
// mfhi/mflo result, and flags any disagreement with the unit's busy flag.
//
// Issue handshake: md_start is a one-cycle pulse with no back-pressure; the
// unit accepts it unconditionally on the edge where it is high.  The
// controller only raises it when its FSM is IDLE and req is low, so the unit
// is never started while busy.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      instr_e,
    input  logic             md_busy,
    input  logic [31:0]      hi,
    input  logic [31:0]      lo,
    output logic             md_start,
    output logic             md_stall,
    output logic [31:0]      md_rdata,
    output logic             md_rd_en,
    output logic             seq_err,
    output md_state_t        dbg_state,
    output logic [CNT_W-1:0] dbg_rem
);

    // D-stage classification
    logic d_start, d_mul, d_div, d_mfhi, d_mflo, d_mdclass;
    // E-stage classification
    logic e_start, e_mul, e_div, e_mfhi, e_mflo, e_mdclass;

    md_state_t        state;
    logic [CNT_W-1:0] rem;
    logic             armed;
    logic             busy_view;
    logic             illegal_start;
    logic             unused_dec;

    md_decode u_dec_d (
        .instr      (instr_d),
        .is_start   (d_start),
        .is_mul     (d_mul),
        .is_div     (d_div),
        .is_mfhi    (d_mfhi),
        .is_mflo    (d_mflo),
        .is_mdclass (d_mdclass)
    );

    md_decode u_dec_e (
        .instr      (instr_e),
        .is_start   (e_start),
        .is_mul     (e_mul),
        .is_div     (e_div),
        .is_mfhi    (e_mfhi),
        .is_mflo    (e_mflo),
        .is_mdclass (e_mdclass)
    );

    // Only the class flag matters in D; only the start/read flags matter in E
    assign unused_dec = ^{d_start, d_mul, d_div, d_mfhi, d_mflo, e_div, e_mdclass};

    // The FSM's view of whether the unit should currently be busy
    assign busy_view = (state != ST_IDLE);

    // A start reaching E while an operation is outstanding slipped past the stall
    assign illegal_start = e_start & busy_view;

    assign md_start = e_start & ~req & (state == ST_IDLE);
    assign md_stall = d_mdclass & (md_start | busy_view);
    assign md_rd_en = e_mfhi | e_mflo;

    // HI/LO read mux for the E/M pipeline register
    always_comb begin
        md_rdata = 32'h0;
        if (e_mfhi) begin
            md_rdata = hi;
        end else if (e_mflo) begin
            md_rdata = lo;
        end
    end

    // Latency tracker: counts the unit's busy cycles, frozen while req is high
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            rem   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        if (e_mul) begin
                            state <= ST_MUL;
                            rem   <= CNT_W'(MUL_CYCLES);
                        end else begin
                            state <= ST_DIV;
                            rem   <= CNT_W'(DIV_CYCLES);
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (!req) begin
                        if (rem == CNT_W'(1)) begin
                            state <= ST_IDLE;
                            rem   <= '0;
                        end else begin
                            rem <= rem - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    rem   <= '0;
                end
            endcase
        end
    end

    // Sticky consistency check against the unit, armed by the first start
    always_ff @(posedge clk) begin
        if (reset) begin
            armed   <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            if (md_start) begin
                armed <= 1'b1;
            end
            if (armed && (md_busy != busy_view)) begin
                seq_err <= 1'b1;
            end
            if (illegal_start) begin
                seq_err <= 1'b1;
            end
        end
    end

    assign dbg_state = state;
    assign dbg_rem   = rem;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl with a behavioural MD unit model
// that drives md_busy from the controller's start pulse.
module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_ADD   = 32'h0085_1020;
    localparam logic [31:0] I_MULT  = 32'h0085_0018;
    localparam logic [31:0] I_MULTU = 32'h0085_0019;
    localparam logic [31:0] I_DIV   = 32'h0085_001A;
    localparam logic [31:0] I_DIVU  = 32'h0085_001B;
    localparam logic [31:0] I_MFHI  = 32'h0000_1010;
    localparam logic [31:0] I_MFLO  = 32'h0000_1012;
    localparam logic [31:0] I_MTHI  = 32'h0040_0011;
    localparam logic [31:0] I_MTLO  = 32'h0040_0013;
    localparam logic [31:0] I_BOGUS = 32'h0400_0018;

    logic        clk;
    logic        reset;
    logic        req;
    logic [31:0] instr_d;
    logic [31:0] instr_e;
    logic        md_busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_start;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic        md_rd_en;
    logic        seq_err;
    md_state_t   dbg_state;
    logic [3:0]  dbg_rem;

    int total = 0;
    int bad   = 0;

    logic [1:0]  exp_q[$];
    logic [32:0] rd_q[$];

    int   busy_cnt;
    logic busy_force;

    md_issue_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .instr_d   (instr_d),
        .instr_e   (instr_e),
        .md_busy   (md_busy),
        .hi        (hi),
        .lo        (lo),
        .md_start  (md_start),
        .md_stall  (md_stall),
        .md_rdata  (md_rdata),
        .md_rd_en  (md_rd_en),
        .seq_err   (seq_err),
        .dbg_state (dbg_state),
        .dbg_rem   (dbg_rem)
    );

    // Clock / time limit
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // MD unit model: busy for 5 (mul) or 10 (div) non-req cycles after a start
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
        end else if (md_start) begin
            busy_cnt <= ((instr_e[5:0] == 6'b011000) || (instr_e[5:0] == 6'b011001)) ? 5 : 10;
        end else if (busy_cnt != 0 && !req) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign md_busy = (busy_cnt != 0) | busy_force;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = 1'b0;
        instr_d = I_NOP;
        instr_e = I_NOP;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        hi = 32'h1111_2222;
        lo = 32'h3333_4444;
        busy_force = 1'b0;
        do_reset();
        @(negedge clk);
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        total++; if (dbg_rem !== 4'd0) begin bad++; $display("FAIL reset_rem: got %0d want 0", dbg_rem); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
        total++; if ({md_start, md_stall} !== 2'b00) begin bad++; $display("FAIL reset_start_stall: got %b want 00", {md_start, md_stall}); end
        total++; if ({md_rd_en, md_rdata} !== 33'h0) begin bad++; $display("FAIL reset_rd: got %h want 0", {md_rd_en, md_rdata}); end
        next_cycle();
    endtask

    task automatic test_mult_stall();
        logic [1:0] e;
        instr_d = I_MFHI;
        instr_e = I_MULT;
        exp_q.push_back(2'b11);
        repeat (5) exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if ({md_start, md_stall} !== e) begin bad++; $display("FAIL mult_cycle%0d start_stall: got %b want %b", c, {md_start, md_stall}, e); end
            if (c > 0) begin
                total++; if (md_stall !== md_busy) begin bad++; $display("FAIL mult_cycle%0d stall_vs_busy: got %b want %b", c, md_stall, md_busy); end
            end
            total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL mult_cycle%0d seq_err: got %b want 0", c, seq_err); end
            next_cycle();
            instr_e = I_NOP;
        end
        instr_d = I_NOP;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        instr_d = I_MULTU;
        instr_e = I_MULT;
        exp_q.push_back(2'b11);
        repeat (5) exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if ({md_start, md_stall} !== e) begin bad++; $display("FAIL b2b_cycle%0d start_stall: got %b want %b", c, {md_start, md_stall}, e); end
            next_cycle();
            if (c == 6) begin
                instr_e = I_MULTU;
                instr_d = I_NOP;
            end else begin
                instr_e = I_NOP;
            end
        end
        repeat (6) next_cycle();
        @(negedge clk);
        total++; if (dbg_state !== ST_IDLE || seq_err !== 1'b0) begin bad++; $display("FAIL b2b_done: got state=%0d seq_err=%b want state=0 seq_err=0", dbg_state, seq_err); end
        next_cycle();
    endtask

    task automatic test_div_rdata();
        logic [1:0]  e;
        logic [32:0] r;
        logic [31:0] a;
        logic [31:0] b;
        a = 32'h0000_000A;
        b = 32'h0000_0003;
        instr_d = I_MFLO;
        instr_e = I_DIVU;
        exp_q.push_back(2'b11);
        repeat (10) exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if ({md_start, md_stall} !== e) begin bad++; $display("FAIL divu_cycle%0d start_stall: got %b want %b", c, {md_start, md_stall}, e); end
            next_cycle();
            instr_e = I_NOP;
            if (c == 10) begin
                hi = a % b;
                lo = a / b;
            end
        end
        // The released mflo reaches E, then an mfhi, then a non-MD instruction
        rd_q.push_back({1'b1, 32'h0000_0003});
        rd_q.push_back({1'b1, 32'h0000_0001});
        rd_q.push_back({1'b0, 32'h0000_0000});
        instr_e = I_MFLO;
        instr_d = I_MFHI;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            r = rd_q.pop_front();
            total++; if ({md_rd_en, md_rdata} !== r) begin bad++; $display("FAIL divu_read%0d: got %b/%h want %b/%h", c, md_rd_en, md_rdata, r[32], r[31:0]); end
            total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL divu_read%0d stall: got %b want 0", c, md_stall); end
            next_cycle();
            instr_e = (c == 0) ? I_MFHI : I_ADD;
            instr_d = I_NOP;
        end
        instr_e = I_NOP;
    endtask

    task automatic test_req_hold();
        logic [1:0] e;
        int         r_exp;
        logic [3:0] rem_exp;
        r_exp   = 0;
        instr_d = I_MFHI;
        instr_e = I_DIV;
        for (int c = 0; c < 16; c++) begin
            req = (c >= 7 && c <= 9);
            exp_q.push_back({(c == 0), (c == 0) || (r_exp != 0)});
            rem_exp = 4'(r_exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if ({md_start, md_stall} !== e) begin bad++; $display("FAIL req_cycle%0d start_stall: got %b want %b", c, {md_start, md_stall}, e); end
            total++; if (dbg_rem !== rem_exp) begin bad++; $display("FAIL req_cycle%0d rem: got %0d want %0d", c, dbg_rem, rem_exp); end
            if (c > 0) begin
                total++; if (md_stall !== md_busy) begin bad++; $display("FAIL req_cycle%0d stall_vs_busy: got %b want %b", c, md_stall, md_busy); end
            end
            if (c == 0) r_exp = 10;
            else if (r_exp != 0 && !req) r_exp = r_exp - 1;
            next_cycle();
            instr_e = I_NOP;
        end
        req = 1'b0;
        @(negedge clk);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL req_seq_err: got %b want 0", seq_err); end
        instr_d = I_NOP;
        next_cycle();
    endtask

    task automatic test_start_with_req();
        instr_d = I_MFLO;
        instr_e = I_MULT;
        req     = 1'b1;
        @(negedge clk);
        total++; if ({md_start, md_stall} !== 2'b00) begin bad++; $display("FAIL startreq start_stall: got %b want 00", {md_start, md_stall}); end
        next_cycle();
        req     = 1'b0;
        instr_e = I_NOP;
        @(negedge clk);
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL startreq state: got %0d want %0d", dbg_state, ST_IDLE); end
        total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL startreq stall_after: got %b want 0", md_stall); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL startreq seq_err: got %b want 0", seq_err); end
        instr_d = I_NOP;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        instr_d = I_NOP;
        instr_e = I_DIV;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            instr_e = I_NOP;
        end
        reset   = 1'b1;
        instr_d = I_MFHI;
        @(negedge clk);
        total++; if (dbg_rem !== 4'd2) begin bad++; $display("FAIL rstmid rem_before: got %0d want 2", dbg_rem); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rstmid state: got %0d want %0d", dbg_state, ST_IDLE); end
        total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL rstmid stall: got %b want 0", md_stall); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL rstmid seq_err: got %b want 0", seq_err); end
        instr_d = I_NOP;
        next_cycle();
    endtask

    task automatic test_busy_overrun();
        instr_d = I_NOP;
        instr_e = I_MULT;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            instr_e = I_NOP;
        end
        busy_force = 1'b1;
        @(negedge clk);
        total++; if (seq_err !== 1'b0 || dbg_state !== ST_IDLE) begin bad++; $display("FAIL overrun pre: got seq_err=%b state=%0d want 0/0", seq_err, dbg_state); end
        next_cycle();
        busy_force = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL overrun sticky%0d: got %b want 1", c, seq_err); end
            next_cycle();
        end
        do_reset();
        @(negedge clk);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL overrun cleared: got %b want 0", seq_err); end
        next_cycle();
    endtask

    task automatic test_illegal_start();
        instr_d = I_NOP;
        instr_e = I_MULT;
        next_cycle();
        instr_e = I_MULTU;
        @(negedge clk);
        total++; if (md_start !== 1'b0 || seq_err !== 1'b0) begin bad++; $display("FAIL illegal pulse: got start=%b seq_err=%b want 0/0", md_start, seq_err); end
        next_cycle();
        instr_e = I_NOP;
        @(negedge clk);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL illegal seq_err: got %b want 1", seq_err); end
        repeat (6) next_cycle();
        do_reset();
    endtask

    task automatic test_decode_misc();
        instr_e = I_BOGUS;
        instr_d = I_MTHI;
        @(negedge clk);
        total++; if ({md_start, md_stall} !== 2'b00) begin bad++; $display("FAIL decode bogus: got %b want 00", {md_start, md_stall}); end
        next_cycle();
        instr_e = I_MULTU;
        @(negedge clk);
        total++; if ({md_start, md_stall} !== 2'b11) begin bad++; $display("FAIL decode mthi_start: got %b want 11", {md_start, md_stall}); end
        next_cycle();
        instr_e = I_NOP;
        instr_d = I_ADD;
        @(negedge clk);
        total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL decode add_busy: got %b want 0", md_stall); end
        next_cycle();
        instr_d = I_MTLO;
        @(negedge clk);
        total++; if (md_stall !== 1'b1) begin bad++; $display("FAIL decode mtlo_busy: got %b want 1", md_stall); end
        next_cycle();
        instr_d = I_NOP;
        repeat (5) next_cycle();
        @(negedge clk);
        total++; if (dbg_state !== ST_IDLE || seq_err !== 1'b0) begin bad++; $display("FAIL decode done: got state=%0d seq_err=%b want 0/0", dbg_state, seq_err); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_mult_stall();
        test_back_to_back();
        test_div_rdata();
        test_req_hold();
        test_start_with_req();
        test_reset_mid();
        test_busy_overrun();
        test_illegal_start();
        test_decode_misc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
